// File: rtl/ex_muldiv_unit.sv
// RV32M iterative multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [4:0]      rd_in,
  output logic            stall_out,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int W2 = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [4:0]      cnt;
  logic [2:0]      f3;
  logic [4:0]      rd_q;
  logic [W2-1:0]   mcand;
  logic [W2-1:0]   acc;
  logic [XLEN-1:0] opb;
  logic            neg_q;
  logic            neg_r;

  logic            sg1;
  logic            sg2;
  logic            n1;
  logic            n2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            is_div;
  logic            div_zero;
  logic            div_ovf;
  logic            fast;
  logic [XLEN-1:0] fast_res;
  logic            go;

  always_comb begin
    sg1 = 1'b0;
    sg2 = 1'b0;
    unique case (funct3_in)
      3'b000: begin sg1 = 1'b1; sg2 = 1'b1; end
      3'b001: begin sg1 = 1'b1; sg2 = 1'b1; end
      3'b010: begin sg1 = 1'b1; sg2 = 1'b0; end
      3'b011: begin sg1 = 1'b0; sg2 = 1'b0; end
      3'b100: begin sg1 = 1'b1; sg2 = 1'b1; end
      3'b101: begin sg1 = 1'b0; sg2 = 1'b0; end
      3'b110: begin sg1 = 1'b1; sg2 = 1'b1; end
      3'b111: begin sg1 = 1'b0; sg2 = 1'b0; end
    endcase
  end

  assign n1   = sg1 & rs1_data_in[XLEN-1];
  assign n2   = sg2 & rs2_data_in[XLEN-1];
  assign mag1 = n1 ? -rs1_data_in : rs1_data_in;
  assign mag2 = n2 ? -rs2_data_in : rs2_data_in;
  assign go   = start & ~flush;

  assign is_div   = funct3_in[2];
  assign div_zero = rs2_data_in == '0;
  assign div_ovf  = ~funct3_in[0]
                  & (rs1_data_in == MIN_NEG)
                  & (rs2_data_in == ALL_ONE);
  assign fast     = is_div & (div_zero | div_ovf);

  always_comb begin
    fast_res = '0;
    unique case (1'b1)
      div_zero: fast_res = funct3_in[1] ? rs1_data_in : ALL_ONE;
      default:  fast_res = funct3_in[1] ? '0 : MIN_NEG;
    endcase
  end

  logic [W2-1:0]   acc_mul;
  logic [W2-1:0]   acc_div;
  logic [W2-1:0]   acc_nxt;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [W2-1:0]   prod_s;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] remv;
  logic [XLEN-1:0] calc_res;

  assign acc_mul = acc + (opb[0] ? mcand : '0);
  assign shifted = acc[W2-1:XLEN-1];
  assign trial   = shifted - {1'b0, opb};

  // Restore on borrow: keep the shifted partial remainder.
  always_comb begin
    if (!trial[XLEN])
      acc_div = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_div = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  assign acc_nxt = f3[2] ? acc_div : acc_mul;
  assign prod_s  = neg_q ? -acc_nxt : acc_nxt;
  assign quo     = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
  assign remv    = neg_r ? -acc_nxt[W2-1:XLEN] : acc_nxt[W2-1:XLEN];

  always_comb begin
    calc_res = '0;
    unique case (f3)
      3'b000:  calc_res = prod_s[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  calc_res = prod_s[W2-1:XLEN];
      3'b100,
      3'b101:  calc_res = quo;
      default: calc_res = remv;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (go) state_nxt = fast ? DONE : CALC;
      CALC: begin
        if (flush)
          state_nxt = IDLE;
        else if (cnt == 5'd31)
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      f3     <= '0;
      rd_q   <= '0;
      mcand  <= '0;
      acc    <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            f3    <= funct3_in;
            rd_q  <= rd_in;
            cnt   <= '0;
            neg_q <= n1 ^ n2;
            neg_r <= n1;
            mcand <= {{XLEN{1'b0}}, mag1};
            opb   <= mag2;
            acc   <= is_div ? {{XLEN{1'b0}}, mag1} : '0;
            if (fast) begin
              result <= fast_res;
              rd_out <= rd_in;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            opb   <= f3[2] ? opb : opb >> 1;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result <= calc_res;
              rd_out <= rd_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_out = (state == IDLE && go) || state == CALC;
  assign done      = state == DONE;

endmodule
